// File: rtl/amplitude_pkg.sv
// Shared types and helpers for the amplitude ramp volume stage.
package amplitude_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        EMIT = 2'd2
    } state_e;

    // The gain table below is written for 14 fractional bits.
    localparam int LUT_GQ = 14;
    localparam int UNITY  = 1 << LUT_GQ;
    localparam int WIDE   = 64;

    function automatic int unity(input int gq);
        return 1 << gq;
    endfunction

    // Switch code to target gain, rescaled to the caller's fractional width.
    function automatic logic signed [31:0] gain_lut(input logic [2:0] sel, input int gq);
        logic signed [31:0] base;
        case (sel)
            3'd0:    base = 32'sh0000_0000;
            3'd1:    base = 32'sh0000_1000;
            3'd2:    base = 32'sh0000_2000;
            3'd3:    base = 32'sh0000_2D41;
            3'd4:    base = 32'sh0000_4000;
            3'd5:    base = 32'sh0000_5A82;
            3'd6:    base = 32'sh0000_6000;
            default: base = 32'sh0000_7000;
        endcase
        if (gq >= LUT_GQ) return base <<< (gq - LUT_GQ);
        else              return base >>> (LUT_GQ - gq);
    endfunction

    // Clamp a wide signed value into the range of a bits-wide signed number.
    function automatic logic signed [WIDE-1:0] sat(input logic signed [WIDE-1:0] value,
                                                   input int bits);
        logic signed [WIDE-1:0] hi;
        logic signed [WIDE-1:0] lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bits - 1));
        if (value > hi)      return hi;
        else if (value < lo) return lo;
        else                 return value;
    endfunction

endpackage

// File: rtl/gain_ramp.sv
// Target-gain selection from panel switches and a slew-limited gain register.
// The gain only moves when step_i is pulsed, so the owner decides the update rate.
module gain_ramp
    import amplitude_pkg::*;
#(
    parameter int GW        = 16,
    parameter int GQ        = 14,
    parameter int RAMP_STEP = 16'h0200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           gain_sel_i,
    input  logic                 step_i,
    output logic signed [GW-1:0] gain_o
);

    localparam logic signed [GW:0] STEP = (GW+1)'(RAMP_STEP);

    logic [2:0]           sync1_q, sync2_q, sel_q;
    logic signed [31:0]   lut_full;
    logic signed [GW-1:0] target;
    logic signed [GW:0]   diff;
    logic signed [GW-1:0] gain_q, gain_d;

    // Two-flop synchronizer, then accept a code only once it has been seen on two
    // consecutive clocks so a switch bounce shorter than two cycles never lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 3'd0;
            sync2_q <= 3'd0;
            sel_q   <= 3'd0;
        end else begin
            sync1_q <= gain_sel_i;
            sync2_q <= sync1_q;
            if (sync1_q == sync2_q) sel_q <= sync2_q;
        end
    end

    assign lut_full = gain_lut(sel_q, GQ);
    assign target   = GW'(lut_full);

    // Slew toward the target by at most one step; land exactly when within reach.
    always_comb begin
        gain_d = gain_q;
        diff   = (GW+1)'(target) - (GW+1)'(gain_q);
        if (step_i) begin
            if (diff > STEP)       gain_d = gain_q + GW'(STEP);
            else if (diff < -STEP) gain_d = gain_q - GW'(STEP);
            else                   gain_d = target;
        end
    end

    // Gain register starts muted so the output fades in after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) gain_q <= '0;
        else        gain_q <= gain_d;
    end

    assign gain_o = gain_q;

endmodule

// File: rtl/amplitude_ramp_mc.sv
// Multi-channel PCM volume stage: one shared multiplier walks the channels of a
// frame, then the assembled frame is emitted and the gain slews one step.
//
// state | meaning
// IDLE  | ready for a frame; accept latches samples and the frame gain
// MAC   | one channel per cycle through the shared multiplier
// EMIT  | out_valid pulse with the new frame; gain takes one ramp step
module amplitude_ramp_mc
    import amplitude_pkg::*;
#(
    parameter int BITS      = 16,
    parameter int CH        = 2,
    parameter int GW        = 16,
    parameter int GQ        = 14,
    parameter int RAMP_STEP = 16'h0200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           gain_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*BITS-1:0]   in_data,
    output logic                 out_valid,
    output logic [CH*BITS-1:0]   out_data,
    output logic [CH-1:0]        clip,
    output logic [GW-1:0]        cur_gain
);

    localparam int IW = (CH > 1) ? $clog2(CH) : 1;
    localparam int PW = BITS + GW;
    localparam logic signed [PW:0] ROUND = (PW+1)'(unity(GQ) / 2);

    state_e               state_q, state_d;
    logic [CH*BITS-1:0]   frame_q, frame_d;
    logic signed [GW-1:0] fgain_q, fgain_d;
    logic [IW-1:0]        ch_q, ch_d;
    logic [CH*BITS-1:0]   res_q, res_d, out_q, out_d;
    logic [CH-1:0]        clipacc_q, clipacc_d, clip_q, clip_d;
    logic                 step;
    logic signed [GW-1:0] gain;

    logic signed [BITS-1:0] sample;
    logic signed [PW-1:0]   prod;
    logic signed [PW:0]     rnd;
    logic signed [WIDE-1:0] r_ext, r_sat;
    logic signed [BITS-1:0] lane_out;
    logic                   lane_clip;

    gain_ramp #(
        .GW        (GW),
        .GQ        (GQ),
        .RAMP_STEP (RAMP_STEP)
    ) u_gain_ramp (
        .clk        (clk),
        .rst_n      (rst_n),
        .gain_sel_i (gain_sel),
        .step_i     (step),
        .gain_o     (gain)
    );

    // Shared datapath for the channel selected by ch_q: multiply, round half up, saturate.
    assign sample    = frame_q[int'(ch_q)*BITS +: BITS];
    assign prod      = PW'(sample) * PW'(fgain_q);
    assign rnd       = (PW+1)'(prod) + ROUND;
    assign r_ext     = WIDE'(rnd >>> GQ);
    assign r_sat     = sat(r_ext, BITS);
    assign lane_out  = BITS'(r_sat);
    assign lane_clip = (r_sat != r_ext);

    // Next-state and datapath control; the full frame is published only on entry to EMIT.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        fgain_d   = fgain_q;
        ch_d      = ch_q;
        res_d     = res_q;
        out_d     = out_q;
        clipacc_d = clipacc_q;
        clip_d    = clip_q;
        step      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    frame_d = in_data;
                    fgain_d = gain;
                    ch_d    = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                res_d[int'(ch_q)*BITS +: BITS] = lane_out;
                clipacc_d[ch_q]                = lane_clip;
                ch_d                           = ch_q + 1'b1;
                if (ch_q == IW'(CH - 1)) begin
                    out_d   = res_d;
                    clip_d  = clipacc_d;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                step    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and frame registers; reset discards any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            fgain_q   <= '0;
            ch_q      <= '0;
            res_q     <= '0;
            out_q     <= '0;
            clipacc_q <= '0;
            clip_q    <= '0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            fgain_q   <= fgain_d;
            ch_q      <= ch_d;
            res_q     <= res_d;
            out_q     <= out_d;
            clipacc_q <= clipacc_d;
            clip_q    <= clip_d;
        end
    end

    assign in_ready  = rst_n & (state_q == IDLE);
    assign out_valid = (state_q == EMIT);
    assign out_data  = out_q;
    assign clip      = clip_q;
    assign cur_gain  = gain;

endmodule
